// File: rtl/vga_framebuffer_scan.sv
// vga_framebuffer_scan: 160x120x3 framebuffer with a pixel-plot write port and raster scan-out.
// The optional power-on clear is enabled by defining FB_CLEAR_ON_RESET_EN.
module vga_framebuffer_scan #(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned V_ACTIVE = 120,
  parameter int unsigned H_FP     = 4,
  parameter int unsigned H_SYNC   = 24,
  parameter int unsigned H_BP     = 12,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  output logic [2:0] pix_colour,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       active,
  output logic       frame_start,
  output logic       clear_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned AW      = 15;
  localparam int unsigned DEPTH   = H_ACTIVE * V_ACTIVE;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]    X_LIM    = 8'(H_ACTIVE);
  localparam logic [6:0]    Y_LIM    = 7'(V_ACTIVE);

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            active_q, active_d;
  logic            hsync_n_q, hsync_n_d;
  logic            vsync_n_q, vsync_n_d;
  logic            frame_start_q, frame_start_d;
  logic [AW-1:0]   rd_addr;
  logic [2:0]      rd_data_q;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [2:0]      wr_data;
  logic [2:0]      mem [DEPTH];

`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  // Clear walker: one address per cycle in INIT, leave for RUN on the last address
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == INIT) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == CLR_LAST) begin
        state_d = RUN;
      end
    end
  end

  // State and clear-address registers; reset restarts the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Busy flag follows the INIT state
  always_comb begin
    clear_busy = (state_q == INIT);
  end
`else
  // Without the clear there is nothing to sequence: always RUN
  always_comb begin
    state_d = RUN;
  end

  // State register, reset straight into RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // No clear logic present
  always_comb begin
    clear_busy = 1'b0;
  end
`endif

  // Write port select: in-range plots in RUN, or the clear walker in INIT
  always_comb begin
    wr_en   = vga_plot && (vga_x < X_LIM) && (vga_y < Y_LIM) && (state_q == RUN);
    wr_addr = AW'(vga_y) * AW'(H_ACTIVE) + AW'(vga_x);
    wr_data = vga_colour;
`ifdef FB_CLEAR_ON_RESET_EN
    if (state_q == INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = '0;
    end
`endif
  end

  // Stage 0: counter advance, timing decode and read address
  always_comb begin
    h_cnt_d       = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d       = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    active_d      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT) && (state_q == RUN);
    hsync_n_d     = !((h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E));
    vsync_n_d     = !((v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E));
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    rd_addr       = '0;
    if ((h_cnt_q < H_ACT) && (v_cnt_q < V_ACT)) begin
      rd_addr = AW'(v_cnt_q) * AW'(H_ACTIVE) + AW'(h_cnt_q);
    end
  end

  // Counters and stage-1 timing flags, aligned with the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_q      <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active_q      <= active_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Framebuffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Framebuffer read port; a same-cycle write is seen only from the next read
  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr];
  end

  // Output drive; colour blanked whenever the pixel is not visible
  always_comb begin
    pix_colour  = active_q ? rd_data_q : '0;
    active      = active_q;
    hsync_n     = hsync_n_q;
    vsync_n     = vsync_n_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_vga_framebuffer_scan.sv
// Directed bench for vga_framebuffer_scan: plots, raster timing, collision, mid-frame reset.
module tb_vga_framebuffer_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] vga_x = '0;
  logic [6:0] vga_y = '0;
  logic [2:0] vga_colour = '0;
  logic       vga_plot = 1'b0;
  logic [2:0] pix_colour;
  logic       hsync_n;
  logic       vsync_n;
  logic       active;
  logic       frame_start;
  logic       clear_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int pos    = 0;  // output pixel offset since the last frame_start sample point

  vga_framebuffer_scan dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .pix_colour  (pix_colour),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .active      (active),
    .frame_start (frame_start),
    .clear_busy  (clear_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    pos++;
  endtask

  task automatic goto(input int target);
    while (pos < target) step();
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
    step();
    vga_plot = 1'b0;
  endtask

  localparam int FRAME = 26600;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pix", 32'(pix_colour), 0);
    chk("rst_hsync", 32'(hsync_n), 1);
    chk("rst_vsync", 32'(vsync_n), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_busy", 32'(clear_busy), 0);

    // Release: first frame_start one cycle later
    rst_n = 1'b1;
    @(negedge clk);
    pos = 0;
    chk("f1_fs", 32'(frame_start), 1);
    chk("f1_hs0", 32'(hsync_n), 1);

    // Plots, including two out-of-range ones (x=160,y=5 would alias (0,6))
    plot(8'd0, 7'd0, 3'd7);
    plot(8'd159, 7'd119, 3'd4);
    plot(8'd0, 7'd6, 3'd1);
    plot(8'd10, 7'd10, 3'd2);
    plot(8'd50, 7'd60, 3'd6);
    plot(8'd160, 7'd5, 3'd7);
    plot(8'd3, 7'd120, 3'd7);

    // Line 0 horizontal timing
    goto(159); chk("act_159", 32'(active), 1);
    goto(160); chk("act_160", 32'(active), 0);
    chk("blank_160", 32'(pix_colour), 0);
    goto(163); chk("hs_163", 32'(hsync_n), 1);
    goto(164); chk("hs_164", 32'(hsync_n), 0);
    goto(187); chk("hs_187", 32'(hsync_n), 0);
    goto(188); chk("hs_188", 32'(hsync_n), 1);

    // x=160,y=5 dropped: (0,6) keeps colour 1
    goto(1200); chk("pix_0_6", 32'(pix_colour), 1);
    chk("act_0_6", 32'(active), 1);

    // Collision: write (10,10)=5 while stage 0 reads (10,10)
    goto(2009);
    vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'd5; vga_plot = 1'b1;
    step();
    vga_plot = 1'b0;
    chk("coll_old", 32'(pix_colour), 2);

    goto(23959); chk("pix_159_119", 32'(pix_colour), 4);
    chk("act_159_119", 32'(active), 1);
    goto(23960); chk("act_160_119", 32'(active), 0);

    // Vertical sync: output lines 123..124
    goto(24599); chk("vs_24599", 32'(vsync_n), 1);
    goto(24600); chk("vs_24600", 32'(vsync_n), 0);
    goto(24999); chk("vs_24999", 32'(vsync_n), 0);
    goto(25000); chk("vs_25000", 32'(vsync_n), 1);

    // Frame period
    goto(FRAME - 1); chk("fs_26599", 32'(frame_start), 0);
    goto(FRAME); chk("fs_26600", 32'(frame_start), 1);
    chk("pix_0_0", 32'(pix_colour), 7);
    chk("act_0_0", 32'(active), 1);
    goto(FRAME + 160); chk("blank_f2", 32'(pix_colour), 0);
    goto(FRAME + 2010); chk("coll_new", 32'(pix_colour), 5);

    // Mid-frame reset at output pixel (50,60)
    goto(FRAME + 12050); chk("pix_50_60", 32'(pix_colour), 6);
    rst_n = 1'b0;
    #1;
    chk("arst_pix", 32'(pix_colour), 0);
    chk("arst_act", 32'(active), 0);
    chk("arst_hs", 32'(hsync_n), 1);
    chk("arst_vs", 32'(vsync_n), 1);
    chk("arst_fs", 32'(frame_start), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pos = 0;
    chk("post_fs", 32'(frame_start), 1);
    chk("post_pix_0_0", 32'(pix_colour), 7);
    goto(1); chk("post_fs_1", 32'(frame_start), 0);
    goto(12050); chk("post_pix_50_60", 32'(pix_colour), 6);
    goto(23959); chk("post_pix_159_119", 32'(pix_colour), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
